// File: rtl/alu_ctrl_decoder_pkg.sv
// Shared ALU control codes, RV32I opcodes and the decoded-entry record
// used by the decoder front end and its output skid buffer.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_PASS = 4'b1011;
  localparam logic [3:0] ALU_BEQ  = 4'b1100;
  localparam logic [3:0] ALU_BNE  = 4'b1101;
  localparam logic [3:0] ALU_BLT  = 4'b1110;
  localparam logic [3:0] ALU_BGE  = 4'b1111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef struct packed {
    logic [3:0]  alu_ctrl;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_branch;
    logic        illegal;
  } dec_t;

  // alt selects sub/sra when funct3 is 000/101 respectively
  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_code = ALU_SLL;
      3'b010:  alu_code = ALU_SLT;
      3'b011:  alu_code = ALU_SLTU;
      3'b100:  alu_code = ALU_XOR;
      3'b101:  alu_code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_code = ALU_OR;
      default: alu_code = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_decoder_if.sv
// Fetch-side and execute-side valid/ready channels of the ALU control decoder.
interface alu_ctrl_decoder_if #(parameter int Width = 32);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       alu_ctrl;
  logic             use_imm;
  logic [Width-1:0] imm;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic             reg_write;
  logic             is_branch;
  logic             illegal;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, alu_ctrl, use_imm, imm, rs1, rs2, rd,
           reg_write, is_branch, illegal
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, alu_ctrl, use_imm, imm, rs1, rs2, rd,
           reg_write, is_branch, illegal
  );
endinterface

// File: rtl/alu_ctrl_decoder_op_decode.sv
// Combinational RV32I subset decode: instruction word -> ALU control record.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0]  opcode;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic        is_shift;
  logic        shift_ok;
  logic        r_ok;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  // only srai may carry the 0100000 pattern in imm[11:5]
  assign shift_ok = (f7 == 7'b0000000) || ((f3 == 3'b101) && (f7 == 7'b0100000));
  assign r_ok     = (f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));

  always_comb begin
    dec          = '0;
    dec.alu_ctrl = ALU_ADD;
    dec.illegal  = 1'b1;
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    case (opcode)
      OP_R: begin
        if (r_ok) begin
          dec.alu_ctrl  = alu_code(f3, f7[5]);
          dec.rd        = instr[11:7];
          dec.reg_write = 1'b1;
          dec.illegal   = 1'b0;
        end
      end
      OP_IMM: begin
        if (!is_shift || shift_ok) begin
          dec.alu_ctrl  = alu_code(f3, is_shift && f7[5]);
          dec.use_imm   = 1'b1;
          dec.imm       = is_shift ? {27'd0, instr[24:20]} : imm_i;
          dec.rd        = instr[11:7];
          dec.reg_write = 1'b1;
          dec.illegal   = 1'b0;
        end
      end
      OP_LOAD: begin
        if ((f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111)) begin
          dec.use_imm   = 1'b1;
          dec.imm       = imm_i;
          dec.rd        = instr[11:7];
          dec.reg_write = 1'b1;
          dec.illegal   = 1'b0;
        end
      end
      OP_STORE: begin
        if (f3[2:1] != 2'b11 && f3[2] == 1'b0) begin
          dec.use_imm = 1'b1;
          dec.imm     = imm_s;
          dec.illegal = 1'b0;
        end
      end
      OP_BRANCH: begin
        if (f3[1] == 1'b0) begin
          dec.alu_ctrl  = {2'b11, f3[2], f3[0]};
          dec.imm       = imm_b;
          dec.is_branch = 1'b1;
          dec.illegal   = 1'b0;
        end
      end
      OP_LUI: begin
        dec.alu_ctrl  = ALU_PASS;
        dec.use_imm   = 1'b1;
        dec.imm       = {instr[31:12], 12'd0};
        dec.rd        = instr[11:7];
        dec.reg_write = 1'b1;
        dec.illegal   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_decoder.sv
// ALU control decoder: combinational decode feeding a 2-entry skid buffer
// with registered in_ready/out_valid toward the execute stage.
//
//   state | meaning
//   EMPTY | no entries held, out_valid=0
//   ONE   | head entry valid, skid slot free
//   TWO   | head and skid entries valid, in_ready=0
module alu_ctrl_decoder
  import alu_pkg::*;
#(
  parameter int Width = 32
) (
  input logic               clk,
  input logic               rst_n,
  input logic               flush,
  alu_ctrl_decoder_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

  occ_e state, state_nxt;
  dec_t dec_in;
  dec_t ent0, ent1, ent0_nxt, ent1_nxt;
  logic in_ready_q, out_valid_q;
  logic accept, consume;

  alu_op_decode u_dec (
    .instr (bus.instr),
    .dec   (dec_in)
  );

  assign accept  = bus.in_valid && in_ready_q;
  assign consume = out_valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      ent0        <= '0;
      ent1        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      ent0        <= ent0_nxt;
      ent1        <= ent1_nxt;
      in_ready_q  <= (state_nxt != TWO);
      out_valid_q <= (state_nxt != EMPTY);
    end
  end

  always_comb begin
    state_nxt = state;
    ent0_nxt  = ent0;
    ent1_nxt  = ent1;
    if (flush) begin
      state_nxt = EMPTY;
      ent0_nxt  = '0;
      ent1_nxt  = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            ent0_nxt  = dec_in;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            ent0_nxt = dec_in;
          end else if (accept) begin
            ent1_nxt  = dec_in;
            state_nxt = TWO;
          end else if (consume) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            ent0_nxt  = ent1;
            state_nxt = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_ctrl  = ent0.alu_ctrl;
  assign bus.use_imm   = ent0.use_imm;
  assign bus.imm       = Width'(signed'(ent0.imm));
  assign bus.rs1       = ent0.rs1;
  assign bus.rs2       = ent0.rs2;
  assign bus.rd        = ent0.rd;
  assign bus.reg_write = ent0.reg_write;
  assign bus.is_branch = ent0.is_branch;
  assign bus.illegal   = ent0.illegal;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Directed self-checking bench for alu_ctrl_decoder.
module tb_alu_ctrl_decoder;

  localparam logic [31:0] I_ADD  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_SUB  = 32'h40208233; // sub  x4,x1,x2
  localparam logic [31:0] I_SRAI = 32'h4032D293; // srai x5,x5,3
  localparam logic [31:0] I_LUI  = 32'h123453B7; // lui  x7,0x12345
  localparam logic [31:0] I_BEQ  = 32'hFE208CE3; // beq  x1,x2,-8
  localparam logic [31:0] I_BLTU = 32'hFE20ECE3; // bltu x1,x2,-8
  localparam logic [31:0] I_ZERO = 32'h00000000;
  localparam logic [31:0] I_BADS = 32'hFE32D293; // srai with imm[11:5]=7F

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_ctrl_decoder_if #(.Width(32)) bus();

  alu_ctrl_decoder #(.Width(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_dec(input string tag, input logic [3:0] a, input logic ui,
                         input logic [31:0] im, input logic [4:0] d, input logic rw,
                         input logic br, input logic il);
    chk({tag, ".valid"},  32'(bus.out_valid), 32'd1);
    chk({tag, ".alu"},    32'(bus.alu_ctrl),  32'(a));
    chk({tag, ".useimm"}, 32'(bus.use_imm),   32'(ui));
    chk({tag, ".imm"},    bus.imm,            im);
    chk({tag, ".rd"},     32'(bus.rd),        32'(d));
    chk({tag, ".rw"},     32'(bus.reg_write), 32'(rw));
    chk({tag, ".br"},     32'(bus.is_branch), 32'(br));
    chk({tag, ".ill"},    32'(bus.illegal),   32'(il));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    bus.in_valid = 1'b1;
    bus.instr    = w;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.ready", 32'(bus.in_ready),  32'd1);
    chk("rst.alu",   32'(bus.alu_ctrl),  32'd0);
    chk("rst.imm",   bus.imm,            32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel.ready", 32'(bus.in_ready), 32'd1);

    // single add, one-cycle latency
    send(I_ADD);
    chk_dec("add", 4'b0010, 1'b0, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("add.rs1", 32'(bus.rs1), 32'd1);
    chk("add.rs2", 32'(bus.rs2), 32'd2);

    // back-to-back stream
    bus.in_valid = 1'b1;
    bus.instr    = I_SUB;
    tick();
    chk_dec("s.sub", 4'b0110, 1'b0, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    bus.instr = I_SRAI;
    tick();
    chk_dec("s.srai", 4'b1010, 1'b1, 32'd3, 5'd5, 1'b1, 1'b0, 1'b0);
    bus.instr = I_LUI;
    tick();
    chk_dec("s.lui", 4'b1011, 1'b1, 32'h12345000, 5'd7, 1'b1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    chk("s.drain", 32'(bus.out_valid), 32'd0);

    // backpressure: out_ready low for 4 edges
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = I_ADD;
    tick();
    chk_dec("bp.a0", 4'b0010, 1'b0, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("bp.rdy0", 32'(bus.in_ready), 32'd1);
    bus.instr = I_SUB;
    tick();
    chk("bp.rdy1", 32'(bus.in_ready), 32'd0);
    chk("bp.hold1", 32'(bus.rd), 32'd3);
    bus.instr = I_LUI;
    tick();
    chk("bp.hold2", 32'(bus.alu_ctrl), 32'b0010);
    tick();
    chk_dec("bp.hold3", 4'b0010, 1'b0, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("bp.rdy3", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    chk_dec("bp.sub", 4'b0110, 1'b0, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("bp.rdy4", 32'(bus.in_ready), 32'd1);
    tick();
    chk_dec("bp.lui", 4'b1011, 1'b1, 32'h12345000, 5'd7, 1'b1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    chk("bp.drain", 32'(bus.out_valid), 32'd0);

    // branch and immediate
    send(I_BEQ);
    chk_dec("beq", 4'b1100, 1'b0, 32'hFFFFFFF8, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("beq.rs1", 32'(bus.rs1), 32'd1);
    chk("beq.rs2", 32'(bus.rs2), 32'd2);
    send(I_BLTU);
    chk_dec("bltu", 4'b0010, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);

    // illegal encodings
    send(I_ZERO);
    chk_dec("zero", 4'b0010, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    send(I_BADS);
    chk_dec("bads", 4'b0010, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("ill.drain", 32'(bus.out_valid), 32'd0);

    // flush with two buffered plus an offered instr
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = I_ADD;
    tick();
    bus.instr = I_SUB;
    tick();
    chk("fl.full", 32'(bus.in_ready), 32'd0);
    bus.instr = I_LUI;
    flush     = 1'b1;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl.valid", 32'(bus.out_valid), 32'd0);
    chk("fl.ready", 32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("fl.none", 32'(bus.out_valid), 32'd0);

    // flush at occupancy 1 drops the instr offered alongside
    bus.out_ready = 1'b0;
    send(I_ADD);
    bus.in_valid = 1'b1;
    bus.instr    = I_SRAI;
    flush        = 1'b1;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl1.valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("fl1.none", 32'(bus.out_valid), 32'd0);

    // async reset mid-stall
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = I_LUI;
    tick();
    bus.instr = I_SUB;
    tick();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.valid", 32'(bus.out_valid), 32'd0);
    chk("ar.ready", 32'(bus.in_ready),  32'd1);
    chk("ar.imm",   bus.imm,            32'd0);
    chk("ar.rd",    32'(bus.rd),        32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("ar.none", 32'(bus.out_valid), 32'd0);
    send(I_SRAI);
    chk_dec("ar.srai", 4'b1010, 1'b1, 32'd3, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    chk("ar.drain", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
